// File: rtl/seg7_score_display_if.sv
// Load/status/segment bundle between a score source and the 7-segment driver.
// The master side requests conversions; the slave side is the display driver.
interface seg7_score_display_if #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH  = 10
);
  logic [BIN_WIDTH-1:0]    value;
  logic                    load;
  logic                    blank_lz;
  logic                    blink_en;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] leds;

  modport master (
    output value, load, blank_lz, blink_en,
    input  busy, done, overflow, leds
  );

  modport slave (
    input  value, load, blank_lz, blink_en,
    output busy, done, overflow, leds
  );
endinterface

// File: rtl/seg7_score_display.sv
// Sequential double-dabble binary-to-BCD converter driving NUM_DIGITS active-low
// 7-segment digits with leading-zero blanking, overflow dashes and blinking.
module seg7_score_display #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH  = 10,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg7_score_display_if.slave  bus
);

  localparam int LED_W = 7 * NUM_DIGITS;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // A limit wider than the input can never be reached, so the compare is simply never true.
  localparam logic [63:0] OVF_LIMIT = 64'(10) ** NUM_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t               state_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 lz_q;
  logic                 ovf_q;
  logic [LED_W-1:0]     disp_q;
  logic [LED_W-1:0]     leds_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 overflow_q;
  logic [BLK_W-1:0]     blink_cnt_q;
  logic                 phase_q;

  logic [BCD_W-1:0]     bcd_adj;
  logic [LED_W-1:0]     new_pat;
  logic [LED_W-1:0]     disp_next;
  logic                 blanked;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: any nibble >= 5 would exceed 9 after the shift.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path can infer a latch.
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Scan from the top digit down so "seen" marks the first nonzero digit.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    new_pat = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) seen = 1'b1;
      if (ovf_q)                           new_pat[7*k +: 7] = SEG_DASH;
      else if (lz_q && !seen && k != 0)    new_pat[7*k +: 7] = SEG_BLANK;
      else                                 new_pat[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
    end
  end

  assign disp_next = (state_q == LATCH) ? new_pat : disp_q;
  assign blanked   = bus.blink_en && !phase_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      lz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      disp_q      <= '1;
      leds_q      <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLK_W'(1);
      end

      disp_q <= disp_next;
      leds_q <= blanked ? '1 : disp_next;
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.load) begin
            bin_q   <= bus.value;
            bcd_q   <= '0;
            lz_q    <= bus.blank_lz;
            ovf_q   <= (64'(bus.value) >= OVF_LIMIT);
            cnt_q   <= CNT_W'(BIN_WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= LATCH;
        end
        LATCH: begin
          overflow_q <= ovf_q;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.leds     = leds_q;

endmodule

// File: tb/tb_seg7_score_display.sv
// Scoreboard bench for seg7_score_display: loads push expected patterns from a
// decimal reference model, a monitor pops and compares on every done pulse.
module tb_seg7_score_display;

  localparam int ND = 3;
  localparam int BW = 10;
  localparam int BD = 4;
  localparam logic [20:0] ALL_BLANK = 21'h1FFFFF;

  typedef struct {
    logic [20:0] leds;
    logic        ovf;
    int          v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seg7_score_display_if #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) bus ();

  seg7_score_display #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [20:0] shown = ALL_BLANK;
  int   edges = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] model_leds(input int v, input bit lz);
    logic [20:0] r;
    int p;
    if (v >= 1000) return {3{7'b0111111}};
    p = 1;
    for (int k = 0; k < ND; k++) begin
      if (lz && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
      else                      r[7*k +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // Edges seen since reset release, to model the free-running blink phase.
  always @(posedge clk) begin
    if (reset) edges = 0;
    else       edges = edges + 1;
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending conversion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("leds_v%0d", e.v), 64'(bus.leds), 64'(e.leds));
        check($sformatf("ovf_v%0d", e.v), 64'(bus.overflow), 64'(e.ovf));
        shown = e.leds;
      end
    end
  end

  // Drives one accepted load; the caller guarantees the DUT is idle.
  task automatic issue(input int v, input bit lz);
    exp_t e;
    e.leds = model_leds(v, lz);
    e.ovf  = (v >= 1000);
    e.v    = v;
    sb.push_back(e);
    bus.value    = BW'(v);
    bus.blank_lz = lz;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_done(input bit check_busy);
    int busy_cnt;
    bit got;
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        got = 1;
        break;
      end
      if (bus.busy) begin
        busy_cnt++;
        if (bus.leds !== shown) check("leds_hold_during_shift", 64'(bus.leds), 64'(shown));
      end
      @(negedge clk);
    end
    if (!got) check("done_timeout", 64'(got), 64'd1);
    if (check_busy) check("busy_cycles", 64'(busy_cnt), 64'(BW + 1));
    check("busy_low_at_done", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.value = '0;
    bus.load = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_leds", 64'(bus.leds), 64'(ALL_BLANK));
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_ovf",  64'(bus.overflow), 64'd0);

    issue(305, 0); wait_done(1);
    issue(7, 1);   wait_done(1);
    issue(0, 1);   wait_done(1);
    issue(999, 0); wait_done(1);
    issue(1000, 0); wait_done(1);
    issue(1023, 1); wait_done(1);
    issue(42, 0);  wait_done(1);

    // Second load while busy must be dropped, not queued.
    issue(123, 0);
    repeat (2) @(negedge clk);
    bus.value = BW'(456);
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    wait_done(0);
    repeat (15) @(negedge clk);
    check("ignored_load_display", 64'(bus.leds), 64'(model_leds(123, 0)));

    for (int i = 0; i < 25; i++) begin
      issue(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
      wait_done(1);
    end

    issue(305, 0); wait_done(1);
    bus.blink_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic ph;
      @(negedge clk);
      ph = 1'b1 ^ 1'(((edges - 1) / BD) & 1);
      check($sformatf("blink_c%0d", i), 64'(bus.leds), 64'(ph ? model_leds(305, 0) : ALL_BLANK));
    end
    bus.blink_en = 1'b0;
    @(negedge clk);
    check("blink_off", 64'(bus.leds), 64'(model_leds(305, 0)));

    // Abort mid-conversion: outputs return to reset values at once, no done.
    issue(500, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_leds", 64'(bus.leds), 64'(ALL_BLANK));
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_ovf",  64'(bus.overflow), 64'd0);
    sb.delete();
    shown = ALL_BLANK;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      check("abort_leds_after", 64'(bus.leds), 64'(ALL_BLANK));
    end

    issue(88, 1); wait_done(1);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_score_display.md
# seg7_score_display

Multi-digit, parametrised 7-segment score driver for the HEX displays. It accepts a binary value on a load strobe and converts it to BCD sequentially, using double-dabble at one bit per clock. It then drives NUM_DIGITS active-low digit patterns from registered outputs, with leading-zero blanking, an overflow indication and a blink mode. It sits between the game's score/lives counters and the board HEX outputs, and replaces per-digit combinational decoders.

## Interface
Parameters:
- NUM_DIGITS, 3: number of decimal digits driven (1–6).
- BIN_WIDTH, 10: width of the binary input value.
- BLINK_DIV, 25000000: clock cycles per blink half-period.

Ports:
- clk  input  1  system clock; every register is clocked on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  BIN_WIDTH  unsigned binary value to display; sampled only on an accepted load.
- load  input  1  conversion request; accepted only in IDLE.
- blank_lz  input  1  when 1, digits above the most significant nonzero digit are blanked; sampled at accept.
- blink_en  input  1  when 1, all digits blink with period 2*BLINK_DIV cycles.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new patterns reach leds.
- overflow  output  1  high while the displayed value is out of range.
- leds  output  7*NUM_DIGITS  active-low segment patterns; digit k occupies [7k+6:7k], bits g..a, digit 0 is least significant.

## Operation
- Encoding (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- State machine IDLE -> SHIFT -> LATCH -> IDLE.
  - IDLE: on load=1, capture value, blank_lz and the overflow condition into the shift, option and flag registers. Clear the BCD accumulator (4*NUM_DIGITS bits). Set the shift counter to BIN_WIDTH and go to SHIFT.
  - SHIFT: in each cycle, add 3 to every BCD nibble that is >= 5. Then shift {bcd, bin} left by one. Decrement the counter. After BIN_WIDTH shifts, go to LATCH.
  - LATCH: build the display patterns from the BCD nibbles, pulse done and return to IDLE.
- load while busy=1 is ignored. The request is not queued.
- Overflow condition: value >= 10**NUM_DIGITS. If that constant exceeds 2**BIN_WIDTH-1, the condition never occurs.
  - On overflow, LATCH shows dash on every digit and sets overflow=1.
  - A non-overflow conversion clears overflow at its LATCH.
- Leading-zero blanking, when blank_lz was set at accept: digit k>0 is blank if it and all higher digits are 0. Digit 0 is always shown. A value of 0 shows blank…blank,"0".
- Blink:
  - A free-running counter runs 0..BLINK_DIV-1 and toggles a phase bit on wrap. Phase resets to 1 (on).
  - When blink_en=1 and phase=0, leds shows all blank. The held display register is unaffected.
  - With blink_en=0, leds shows the display register.

## Timing
- Reset values:
  - state IDLE, busy=0, done=0, overflow=0.
  - leds = all 1s (all digits blank).
  - display register all blank; blink counter 0; phase 1.
- Latency: load sampled at edge E0 sets busy=1 after E0.
  - Shifts occur at edges E1..E_BIN_WIDTH.
  - At edge E_(BIN_WIDTH+1), leds takes the new patterns, done=1 for that one cycle and busy=0.
  - A new load is accepted on the next edge, so the sustained rate is one conversion per BIN_WIDTH+2 cycles.
- leds is registered. A change of blink_en or of the blink phase is visible one cycle later.
- leds holds the previous patterns throughout SHIFT. There is no intermediate flicker.
- Reset asserted mid-conversion aborts immediately and all outputs return to their reset values. No done pulse occurs.
- A value of all-ones that is not in overflow converts normally. The counter wraps only via reload.

## Test plan
Use NUM_DIGITS=3, BIN_WIDTH=10, BLINK_DIV=4.
- Reset then idle: leds=21'h1FFFFF, busy=0, done=0, overflow=0.
- Load 305, blank_lz=0: busy for 11 cycles, then done for 1 cycle. Digits 2..0 = 0110000, 1000000, 0010010.
- Load 7, blank_lz=1: digits = blank, blank, 1111000. Load 0, blank_lz=1: digits = blank, blank, 1000000.
- Load 999: digits 9,9,9, overflow=0. Load 1000: all dash (0111111), overflow=1. Load 42: overflow clears.
- Load 123, then pulse load=1 with 456 at cycle 3 of busy: the second request is ignored and the display shows 123.
- blink_en=1 after 305: leds alternates between the 305 patterns and all-blank every 4 cycles. Reset asserted during SHIFT of a new load: leds goes all-blank immediately and no done pulse occurs.
